aes_sbox_arbiter: RTL and testbench

Shares the single 32-bit AES S-box between two requesters: the key-schedule engine (port K) and the round datapath (port E). It accepts one 32-bit substitution request per cycle with a valid/ack handshake. Accepted words pass through a two-stage registered pipeline to the shared `aes_sbox`, and each result returns to the requester that issued it, tagged with a valid pulse. Arbitration is round-robin with bounded bursts, so a four-word SubWord pass from the round datapath is not interleaved unnecessarily and neither side starves.

---
 rtl/aes_sbox_arbiter.sv | 146 ++++++++++++++
 tb/tb_aes_sbox_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter
// Shares one 32-bit AES S-box between the key-schedule engine (K) and the
// round datapath (E). Each accepted word goes through two registered stages:
// stage 1 drives sboxw, and stage 2 captures new_sboxw into the issuer's
// result register. Arbitration is round-robin with bounded bursts.
// Optional build macro: AES_SBOX_ARB_FIXED_PRIO_EN. When it is defined, K
// always beats E and the burst and round-robin state does not affect grants.
module aes_sbox_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        k_req,
  input  logic [31:0] k_word,
  output logic        k_ack,
  output logic        k_valid,
  output logic [31:0] k_result,
  input  logic        e_req,
  input  logic [31:0] e_word,
  output logic        e_ack,
  output logic        e_valid,
  output logic [31:0] e_result,
  output logic [31:0] sboxw,
  input  logic [31:0] new_sboxw,
  output logic        busy
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_KEY  = 2'd1,
    OWN_ENC  = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_BURST_W = MAX_BURST[3:0];

  owner_t     owner, owner_nxt;
  owner_t     rr_next, rr_nxt;
  owner_t     winner;
  logic [3:0] burst_cnt, burst_nxt;
  logic       grant_k, grant_e;

  // A tag of 1 means the entry belongs to K; 0 means it belongs to E.
  logic       s1_valid, s1_tag;
  logic       s2_valid, s2_tag;

  // Grant selection: a single requester always wins. When both request, the
  // current owner keeps the grant until its burst limit, and then rr_next wins.
  always_comb begin
    grant_k = 1'b0;
    grant_e = 1'b0;
`ifdef AES_SBOX_ARB_FIXED_PRIO_EN
    if (k_req) begin
      grant_k = 1'b1;
    end else if (e_req) begin
      grant_e = 1'b1;
    end else begin
      grant_k = 1'b0;
    end
`else
    if (k_req && !e_req) begin
      grant_k = 1'b1;
    end else if (e_req && !k_req) begin
      grant_e = 1'b1;
    end else if (k_req && e_req) begin
      if ((owner != OWN_NONE) && (burst_cnt < MAX_BURST_W)) begin
        grant_k = (owner == OWN_KEY);
        grant_e = (owner == OWN_ENC);
      end else begin
        grant_k = (rr_next == OWN_KEY);
        grant_e = (rr_next == OWN_ENC);
      end
    end else begin
      grant_k = 1'b0;
    end
`endif
  end

  assign k_ack = k_req & grant_k;
  assign e_ack = e_req & grant_e;

  // Arbiter next state: continue or start a burst on a grant, and return to idle when there is no grant.
  always_comb begin
    owner_nxt = owner;
    burst_nxt = burst_cnt;
    rr_nxt    = rr_next;
    winner    = grant_k ? OWN_KEY : OWN_ENC;
    if (grant_k || grant_e) begin
      if (winner == owner) begin
        burst_nxt = (burst_cnt == 4'd15) ? 4'd15 : (burst_cnt + 4'd1);
      end else begin
        owner_nxt = winner;
        burst_nxt = 4'd1;
      end
      rr_nxt = grant_k ? OWN_ENC : OWN_KEY;
    end else begin
      owner_nxt = OWN_NONE;
      burst_nxt = 4'd0;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= OWN_NONE;
      burst_cnt <= 4'd0;
      rr_next   <= OWN_KEY;
    end else begin
      owner     <= owner_nxt;
      burst_cnt <= burst_nxt;
      rr_next   <= rr_nxt;
    end
  end

  // Two-stage pipeline: stage 1 drives the S-box, and stage 2 captures its output for the issuer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= 1'b0;
      sboxw    <= 32'h0;
      s2_valid <= 1'b0;
      s2_tag   <= 1'b0;
      k_result <= 32'h0;
      e_result <= 32'h0;
    end else begin
      s1_valid <= k_ack | e_ack;
      if (k_ack || e_ack) begin
        s1_tag <= k_ack;
        sboxw  <= k_ack ? k_word : e_word;
      end
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      if (s1_valid) begin
        if (s1_tag) begin
          k_result <= new_sboxw;
        end else begin
          e_result <= new_sboxw;
        end
      end
    end
  end

  assign k_valid = s2_valid & s2_tag;
  assign e_valid = s2_valid & ~s2_tag;
  assign busy    = s1_valid | s2_valid;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Bench for aes_sbox_arbiter. It uses directed stimulus. Expected results are
// pushed to a scoreboard when a request is accepted, and an independent
// monitor checks sboxw, valid pulses, results and latency.
module tb_aes_sbox_arbiter;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic        clk = 1'b0;
  logic        reset_n;
  logic        k_req, e_req;
  logic [31:0] k_word, e_word;
  logic        k_ack, e_ack, k_valid, e_valid, busy;
  logic [31:0] k_result, e_result, sboxw, new_sboxw;

  logic [31:0] k_exp, e_exp;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic        tag;
    logic [31:0] val;
    int          due;
  } sb_t;
  sb_t exp_q[$];
  sb_t sw_q[$];

  logic [31:0] e_words [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
  logic [31:0] e_res   [4] = '{32'h638293c3, 32'h1bfc33f5, 32'hc4eeacea, 32'h4bc12816};

  aes_sbox_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .k_req(k_req), .k_word(k_word), .k_ack(k_ack), .k_valid(k_valid), .k_result(k_result),
    .e_req(e_req), .e_word(e_word), .e_ack(e_ack), .e_valid(e_valid), .e_result(e_result),
    .sboxw(sboxw), .new_sboxw(new_sboxw), .busy(busy)
  );

  assign new_sboxw = {SBOX[sboxw[31:24]], SBOX[sboxw[23:16]], SBOX[sboxw[15:8]], SBOX[sboxw[7:0]]};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Stimulus-side capture: each accepted request pushes its hand-computed expectation.
  always @(negedge clk) begin
    if (k_ack && e_ack) chk("dual_ack", 32'd1, 32'd0);
    if (k_ack) begin
      exp_q.push_back('{1'b1, k_exp, cyc + 2});
      sw_q.push_back('{1'b1, k_word, cyc + 1});
    end else if (e_ack) begin
      exp_q.push_back('{1'b0, e_exp, cyc + 2});
      sw_q.push_back('{1'b0, e_word, cyc + 1});
    end
  end

  // Monitor: checks sboxw one cycle after acceptance and each valid pulse against the scoreboard.
  always @(negedge clk) begin
    sb_t h;
    if (sw_q.size() > 0 && sw_q[0].due == cyc) begin
      h = sw_q.pop_front();
      chk("sboxw", sboxw, h.val);
    end
    if (k_valid && e_valid) chk("dual_valid", 32'd1, 32'd0);
    if (k_valid || e_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {30'd0, k_valid, e_valid}, 32'd0);
      end else begin
        h = exp_q.pop_front();
        chk("valid_tag", {31'd0, k_valid}, {31'd0, h.tag});
        chk("result", h.tag ? k_result : e_result, h.val);
        chk("latency_cycle", cyc, h.due);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      h = exp_q.pop_front();
      chk("missing_valid", 32'd0, h.val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 32'd0);
    chk("drain_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_k_ack"}, {31'd0, k_ack}, 32'd0);
    chk({tag, "_e_ack"}, {31'd0, e_ack}, 32'd0);
    chk({tag, "_k_valid"}, {31'd0, k_valid}, 32'd0);
    chk({tag, "_e_valid"}, {31'd0, e_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_k_result"}, k_result, 32'h0);
    chk({tag, "_e_result"}, e_result, 32'h0);
    chk({tag, "_sboxw"}, sboxw, 32'h0);
  endtask

  // Watchdog: the run must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    k_req = 1'b0; e_req = 1'b0;
    k_word = 32'h0; e_word = 32'h0;
    k_exp = 32'h0; e_exp = 32'h0;
    tick(); tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    reset_n = 1'b1;
    tick();

    // Single K request with word 0.
    k_req = 1'b1; k_word = 32'h00000000; k_exp = 32'h63636363;
    @(negedge clk);
    chk("single_k_ack", {31'd0, k_ack}, 32'd1);
    chk("single_e_ack", {31'd0, e_ack}, 32'd0);
    tick();
    k_req = 1'b0;
    drain();

    // E streams four words on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      tick();
      e_req = 1'b1; e_word = e_words[i]; e_exp = e_res[i];
      @(negedge clk);
      chk("stream_e_ack", {31'd0, e_ack}, 32'd1);
    end
    tick();
    e_req = 1'b0;
    drain();

`ifdef AES_SBOX_ARB_FIXED_PRIO_EN
    // With fixed priority, K wins every contended cycle, and E is served once K drops.
    begin
      int ka = 0;
      int ea = 0;
      k_word = 32'h00000000; k_exp = 32'h63636363;
      e_word = 32'h00112233; e_exp = 32'h638293c3;
      for (int i = 0; i < 10; i++) begin
        tick();
        k_req = 1'b1; e_req = 1'b1;
        @(negedge clk);
        ka += int'(k_ack);
        ea += int'(e_ack);
      end
      chk("fixed_k_acks", ka, 32'd10);
      chk("fixed_e_acks", ea, 32'd0);
      tick();
      k_req = 1'b0;
      @(negedge clk);
      chk("fixed_e_after_k_drop", {31'd0, e_ack}, 32'd1);
      tick();
      e_req = 1'b0;
      drain();
    end
`else
    // Round-robin blocks: E owns the grant first, then the two ports alternate in blocks of four.
    tick();
    e_req = 1'b1; e_word = 32'h00112233; e_exp = 32'h638293c3;
    k_word = 32'h00000000; k_exp = 32'h63636363;
    @(negedge clk);
    chk("rr_e_first", {31'd0, e_ack}, 32'd1);
    tick();
    k_req = 1'b1;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("rr_k_ack", {31'd0, k_ack}, {31'd0, ((i / 4) % 2) == 1});
      chk("rr_e_ack", {31'd0, e_ack}, {31'd0, ((i / 4) % 2) == 0});
      tick();
    end
    k_req = 1'b0; e_req = 1'b0;
    drain();
`endif

    // Reset during flight: the accepted word must never produce a valid pulse.
    tick();
    k_req = 1'b1; k_word = 32'h8899aabb; k_exp = 32'hc4eeacea;
    @(negedge clk);
    chk("pre_reset_ack", {31'd0, k_ack}, 32'd1);
    tick();
    k_req = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    sw_q.delete();
    @(negedge clk);
    check_all_zero("midreset");
    tick(); tick();
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Both ports request from idle after reset: K wins, keeps its burst, and E wins once K drops.
    tick();
    k_req = 1'b1; k_word = 32'h00000000; k_exp = 32'h63636363;
    e_req = 1'b1; e_word = 32'h44556677; e_exp = 32'h1bfc33f5;
    @(negedge clk);
    chk("idle_both_k_wins", {31'd0, k_ack}, 32'd1);
    chk("idle_both_e_waits", {31'd0, e_ack}, 32'd0);
    tick();
    @(negedge clk);
    chk("idle_k_continues", {31'd0, k_ack}, 32'd1);
    tick();
    k_req = 1'b0;
    @(negedge clk);
    chk("idle_e_after_drop", {31'd0, e_ack}, 32'd1);
    tick();
    e_req = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
